// File: rtl/write_arbiter_pkg.sv
// Shared types and constants for the write-address arbiter and its decoder.
// Holds the FSM states, slave regions and one-hot slave encodings.
package write_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } state_t;

  localparam logic [15:0] S0_REGION = 16'h0000;
  localparam logic [15:0] S1_REGION = 16'h0001;

  localparam logic [2:0] SEL_S0  = 3'b100;
  localparam logic [2:0] SEL_S1  = 3'b010;
  localparam logic [2:0] SEL_DEF = 3'b001;

endpackage

// File: rtl/write_arbiter_addr_decoder.sv
// Region decoder: maps address bits [31:16] onto the one-hot slave select.
// Shared by the write and read arbiters.
module addr_decoder
  import write_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [2:0]        sel
);

  logic [15:0] region;
  logic        unused_lo;

  assign region    = addr[31:16];
  assign unused_lo = ^addr[15:0];

  always_comb begin
    sel = SEL_DEF;
    unique case (1'b1)
      (region == S0_REGION): sel = SEL_S0;
      (region == S1_REGION): sel = SEL_S1;
      default:               sel = SEL_DEF;
    endcase
  end

endmodule

// File: rtl/write_arbiter.sv
// Two-master AXI write arbiter with one outstanding transaction.
// Define WARB_RR_EN for round-robin; default is fixed priority M0 > M1.
module write_arbiter
  import write_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int NUM_M  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              AWVALID_M0,
  input  logic              AWVALID_M1,
  input  logic [ADDR_W-1:0] AWADDR_M0,
  input  logic [ADDR_W-1:0] AWADDR_M1,
  input  logic              AWREADY_S,
  input  logic              WVALID_M,
  input  logic              WLAST_M,
  input  logic              WREADY_S,
  input  logic              BVALID_S,
  input  logic              BREADY_M,
  output logic [NUM_M-1:0]  grant,
  output logic [2:0]        slave_sel,
  output logic              aw_en,
  output logic              w_en,
  output logic              b_en,
  output logic              busy
);

  state_t             state;
  state_t             state_nxt;
  logic [NUM_M-1:0]   win;
  logic [NUM_M-1:0]   grant_q;
  logic [2:0]         sel_q;
  logic [2:0]         win_sel;
  logic [ADDR_W-1:0]  win_addr;
  logic               any_req;
  logic               aw_g;
  logic               b_hs;

  assign any_req = AWVALID_M0 | AWVALID_M1;
  assign b_hs    = (state == RESP) & BVALID_S & BREADY_M;

`ifdef WARB_RR_EN
  // ptr=1 gives M1 the tie; flips away from whoever just finished.
  logic ptr;

  always_ff @(posedge clk) begin
    if (!rst)
      ptr <= 1'b0;
    else if (b_hs)
      ptr <= grant_q[0];
  end

  always_comb begin
    win = '0;
    if (AWVALID_M0 && AWVALID_M1) begin
      win[0] = !ptr;
      win[1] = ptr;
    end else begin
      win[0] = AWVALID_M0;
      win[1] = AWVALID_M1;
    end
  end
`else
  always_comb begin
    win    = '0;
    win[0] = AWVALID_M0;
    win[1] = AWVALID_M1 & ~AWVALID_M0;
  end
`endif

  assign win_addr = win[1] ? AWADDR_M1 : AWADDR_M0;

  addr_decoder #(
    .ADDR_W(ADDR_W)
  ) u_dec (
    .addr(win_addr),
    .sel (win_sel)
  );

  // Captured only in IDLE; outputs are masked while IDLE, so no reset needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && any_req) begin
      grant_q <= win;
      sel_q   <= win_sel;
    end
  end

  assign aw_g = grant_q[1] ? AWVALID_M1 : AWVALID_M0;

  always_ff @(posedge clk) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = '0;
    slave_sel = '0;
    aw_en     = 1'b0;
    w_en      = 1'b0;
    b_en      = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (any_req)
          state_nxt = ADDR;
      end
      ADDR: begin
        grant     = grant_q;
        slave_sel = sel_q;
        aw_en     = 1'b1;
        if (aw_g && AWREADY_S)
          state_nxt = DATA;
      end
      DATA: begin
        grant     = grant_q;
        slave_sel = sel_q;
        w_en      = 1'b1;
        if (WVALID_M && WREADY_S && WLAST_M)
          state_nxt = RESP;
      end
      RESP: begin
        grant     = grant_q;
        slave_sel = sel_q;
        b_en      = 1'b1;
        if (b_hs)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_write_arbiter.sv
// Directed self-checking bench for write_arbiter.
// Expected grants follow WARB_RR_EN when the bench is built with it.
module tb_write_arbiter;

  logic        clk;
  logic        rst;
  logic        AWVALID_M0;
  logic        AWVALID_M1;
  logic [31:0] AWADDR_M0;
  logic [31:0] AWADDR_M1;
  logic        AWREADY_S;
  logic        WVALID_M;
  logic        WLAST_M;
  logic        WREADY_S;
  logic        BVALID_S;
  logic        BREADY_M;
  logic [1:0]  grant;
  logic [2:0]  slave_sel;
  logic        aw_en;
  logic        w_en;
  logic        b_en;
  logic        busy;

  int passed = 0;
  int total  = 0;

  write_arbiter #(
    .ADDR_W(32),
    .NUM_M (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .AWVALID_M0(AWVALID_M0),
    .AWVALID_M1(AWVALID_M1),
    .AWADDR_M0 (AWADDR_M0),
    .AWADDR_M1 (AWADDR_M1),
    .AWREADY_S (AWREADY_S),
    .WVALID_M  (WVALID_M),
    .WLAST_M   (WLAST_M),
    .WREADY_S  (WREADY_S),
    .BVALID_S  (BVALID_S),
    .BREADY_M  (BREADY_M),
    .grant     (grant),
    .slave_sel (slave_sel),
    .aw_en     (aw_en),
    .w_en      (w_en),
    .b_en      (b_en),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_in();
    AWVALID_M0 = 1'b0;
    AWVALID_M1 = 1'b0;
    AWADDR_M0  = '0;
    AWADDR_M1  = '0;
    AWREADY_S  = 1'b0;
    WVALID_M   = 1'b0;
    WLAST_M    = 1'b0;
    WREADY_S   = 1'b0;
    BVALID_S   = 1'b0;
    BREADY_M   = 1'b0;
  endtask

  // One full write; stall cycles also raise competing requests/addresses.
  task automatic txn(input string tag, input logic v0, input logic v1,
                     input logic [31:0] a0, input logic [31:0] a1,
                     input int beats, input int aw_dly, input int b_dly,
                     input logic [1:0] eg, input logic [2:0] es);
    AWVALID_M0 = v0;
    AWVALID_M1 = v1;
    AWADDR_M0  = a0;
    AWADDR_M1  = a1;
    step();
    chk({tag, ".addr_grant"}, grant, eg);
    chk({tag, ".addr_sel"}, slave_sel, es);
    chk({tag, ".aw_en"}, aw_en, 1'b1);
    chk({tag, ".addr_busy"}, busy, 1'b1);
    for (int i = 0; i < aw_dly; i++) begin
      AWVALID_M0 = 1'b1;
      AWVALID_M1 = 1'b1;
      AWADDR_M0  = 32'h8000_0000;
      AWADDR_M1  = 32'h0001_0000;
      step();
      chk({tag, ".awstall_en"}, aw_en, 1'b1);
      chk({tag, ".awstall_grant"}, grant, eg);
      chk({tag, ".awstall_sel"}, slave_sel, es);
    end
    AWREADY_S = 1'b1;
    step();
    chk({tag, ".w_en"}, w_en, 1'b1);
    chk({tag, ".data_grant"}, grant, eg);
    AWREADY_S = 1'b0;
    if (aw_dly == 0) begin
      AWVALID_M0 = 1'b0;
      AWVALID_M1 = 1'b0;
    end
    for (int i = 0; i < beats; i++) begin
      WVALID_M = 1'b1;
      WREADY_S = 1'b1;
      WLAST_M  = (i == beats - 1);
      step();
      if (i < beats - 1)
        chk({tag, ".beat_w_en"}, w_en, 1'b1);
      else
        chk({tag, ".last_w_en"}, w_en, 1'b0);
    end
    WVALID_M = 1'b0;
    WREADY_S = 1'b0;
    WLAST_M  = 1'b0;
    chk({tag, ".b_en"}, b_en, 1'b1);
    for (int i = 0; i < b_dly; i++) begin
      step();
      chk({tag, ".bstall_en"}, b_en, 1'b1);
      chk({tag, ".bstall_grant"}, grant, eg);
    end
    BVALID_S = 1'b1;
    BREADY_M = 1'b1;
    step();
    chk({tag, ".idle_busy"}, busy, 1'b0);
    chk({tag, ".idle_grant"}, grant, 2'b00);
    chk({tag, ".idle_sel"}, slave_sel, 3'b000);
    clear_in();
  endtask

  initial begin
    clear_in();
    rst = 1'b0;
    step();
    step();
    chk("rst.grant", grant, 2'b00);
    chk("rst.sel", slave_sel, 3'b000);
    chk("rst.busy", busy, 1'b0);
    chk("rst.en", {aw_en, w_en, b_en}, 3'b000);
    rst = 1'b1;
    step();
    chk("idle.busy", busy, 1'b0);

    txn("single_m1", 1'b0, 1'b1, 32'h0, 32'h0001_0004,
        1, 0, 0, 2'b10, 3'b010);

`ifdef WARB_RR_EN
    txn("both_1", 1'b1, 1'b1, 32'h0000_0020, 32'h0001_0020,
        1, 0, 0, 2'b01, 3'b100);
    txn("both_2", 1'b1, 1'b1, 32'h0000_0020, 32'h0001_0020,
        1, 0, 0, 2'b10, 3'b010);
    txn("both_3", 1'b1, 1'b1, 32'h0000_0020, 32'h0001_0020,
        1, 0, 0, 2'b01, 3'b100);
`else
    txn("both_1", 1'b1, 1'b1, 32'h0000_0020, 32'h0001_0020,
        1, 0, 0, 2'b01, 3'b100);
    txn("both_2", 1'b1, 1'b1, 32'h0000_0020, 32'h0001_0020,
        1, 0, 0, 2'b01, 3'b100);
    txn("both_3", 1'b1, 1'b1, 32'h0000_0020, 32'h0001_0020,
        1, 0, 0, 2'b01, 3'b100);
`endif

    txn("burst4", 1'b1, 1'b0, 32'h0000_0010, 32'h0,
        4, 0, 0, 2'b01, 3'b100);
    txn("unmapped", 1'b1, 1'b0, 32'h8000_0000, 32'h0,
        1, 0, 0, 2'b01, 3'b001);
    txn("stall", 1'b0, 1'b1, 32'h0, 32'h0000_0100,
        2, 3, 5, 2'b10, 3'b100);

    AWVALID_M1 = 1'b1;
    AWADDR_M1  = 32'h0000_0000;
    step();
    chk("rstdata.addr", aw_en, 1'b1);
    AWREADY_S = 1'b1;
    step();
    chk("rstdata.w_en", w_en, 1'b1);
    clear_in();
    rst = 1'b0;
    step();
    chk("rstdata.busy", busy, 1'b0);
    chk("rstdata.grant", grant, 2'b00);
    chk("rstdata.sel", slave_sel, 3'b000);
    chk("rstdata.en", {aw_en, w_en, b_en}, 3'b000);
    rst = 1'b1;
    txn("after_rst", 1'b0, 1'b1, 32'h0, 32'h0001_0008,
        1, 0, 0, 2'b10, 3'b010);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/write_arbiter.md
WRITE_ARBITER -- requirements
Module: write_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning AW address width.
REQ-002 SHALL have parameter NUM_M, default 2, meaning number of write masters (fixed at 2 in this revision).
REQ-003 SHALL have ports clk (in, 1, clock) and rst (in, 1, synchronous active-low reset); one clock, all logic on posedge clk.
REQ-004 SHALL have AWVALID_M0 and AWVALID_M1 (in, 1 each), master write-address requests.
REQ-005 SHALL have AWADDR_M0 and AWADDR_M1 (in, ADDR_W each), master write addresses.
REQ-006 SHALL have AWREADY_S (in, 1), AWREADY of the selected slave.
REQ-007 SHALL have WVALID_M, WLAST_M and WREADY_S (in, 1 each), W beat handshake of the granted path.
REQ-008 SHALL have BVALID_S and BREADY_M (in, 1 each), write response handshake.
REQ-009 SHALL have grant (out, 2), one-hot granted master.
REQ-010 SHALL have slave_sel (out, 3), one-hot {S0,S1,SDEFAULT} destination.
REQ-011 SHALL have aw_en, w_en and b_en (out, 1 each), phase enables for the AW, W and B muxes.
REQ-012 SHALL have busy (out, 1), asserted whenever the state is not IDLE.

Function
REQ-013 SHALL implement a four-state FSM: IDLE, ADDR, DATA, RESP.
REQ-014 IDLE: when any AWVALID_Mx is high, SHALL pick a winner, register grant and slave_sel, and enter ADDR on the next cycle; grant latency is 1 cycle.
REQ-015 SHALL decode the winner's AWADDR[31:16] as follows: 0x0000 -> S0 (100); 0x0001 -> S1 (010); anything else -> SDEFAULT (001).
REQ-016 ADDR: aw_en=1; on AWVALID_Mgrant and AWREADY_S both high, SHALL enter DATA.
REQ-017 DATA: w_en=1; on WVALID_M, WREADY_S and WLAST_M all high, SHALL enter RESP; beats without WLAST SHALL keep the state in DATA.
REQ-018 RESP: b_en=1; on BVALID_S and BREADY_M both high, SHALL return to IDLE, clear grant and slave_sel, and update priority.
REQ-019 grant and slave_sel SHALL remain stable from ADDR through RESP; a new request or AWADDR change mid-transaction SHALL be ignored (outstanding = 1).
REQ-020 If the granted master drops AWVALID while in ADDR, SHALL stay in ADDR; no abort is supported.
REQ-021 In IDLE, grant, slave_sel, aw_en, w_en and b_en SHALL all be 0.
REQ-022 If both requests are high in IDLE, the winner SHALL be chosen per REQ-026/027.

Reset
REQ-023 When rst=0 at posedge clk, SHALL enter IDLE with grant=00, slave_sel=000, all enables 0, busy=0, and priority pointer set to M0.
REQ-024 Reset asserted mid-transaction (any state) SHALL abandon the transaction immediately; no response is generated.
REQ-025 The state register is the only reset-dependent storage, together with the pointer (REQ-023).

Configuration
REQ-026 With WARB_RR_EN defined, SHALL use round-robin arbitration: the last-served master loses ties, and the pointer updates only at the B handshake.
REQ-027 Without WARB_RR_EN, SHALL use fixed priority, M0 over M1; the pointer register SHALL not exist.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, the slave region constants (0x0000, 0x0001) and the one-hot slave_sel encodings.
REQ-029 Address decode SHALL be a sub-module, addr_decoder, reused by the read-side arbiter.

Verification
REQ-030 Single write: M1 AWADDR=0x0001_0004, 1 beat, AWREADY at once -> grant=10, slave_sel=010, IDLE->ADDR->DATA->RESP->IDLE, busy high for exactly those states.
REQ-031 4-beat burst to 0x0000_0010: WLAST on beat 4 only -> stays in DATA for 4 handshakes, then RESP; w_en drops after beat 4.
REQ-032 Simultaneous requests, three back-to-back transactions: with WARB_RR_EN grants are M0, M1, M0; without it, M0, M0, M0.
REQ-033 Unmapped address 0x8000_0000 -> slave_sel=001, and the full handshake completes to IDLE.
REQ-034 Stalls: AWREADY delayed 3 cycles and BVALID delayed 5 cycles -> state holds in ADDR and RESP respectively; grant stays stable; a competing request is ignored until IDLE.
REQ-035 rst=0 asserted in DATA -> next cycle IDLE with all outputs 0; the next request is granted normally.
